sd_drive_arbiter: RTL and testbench
===================================

Name: sd_drive_arbiter

Overview:
- Parametrised successor to the single-drive HDD request handshake in the sim top.
- Serves NUM_DRIVES block devices (floppy/HDD images) against the per-device sd_lba/sd_rd/sd_wr/sd_ack host interface.
- Per drive it provides:
  - latched request capture, with the LBA captured at request time;
  - read-over-write priority;
  - protect/unmounted rejection;
  - ack timeout;
  - optional serialisation with round-robin arbitration.
- Sits between the IIgs disk controllers (SmartPort/IWM glue) and the host SD interface.

Parameters:
NUM_DRIVES, 2, number of drive channels (1..8)
LBA_W, 32, LBA width per channel
TIMEOUT_CYC, 24'd12_000_000, cycles allowed in REQ before ack rise; 0 disables timeout
SERIALIZE, 1, 1 = at most one channel in REQ/XFER at a time (round-robin); 0 = channels independent

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous, active-high reset
drv_sector  in  NUM_DRIVES*LBA_W  per-drive requested LBA, channel i at [i*LBA_W +: LBA_W]
drv_read  in  NUM_DRIVES  one-cycle read request pulse per drive
drv_write  in  NUM_DRIVES  one-cycle write request pulse per drive
drv_busy  out  NUM_DRIVES  CPU-wait: request pending or in flight
drv_done  out  NUM_DRIVES  one-cycle pulse on ack falling edge (transfer complete)
drv_err  out  NUM_DRIVES  one-cycle pulse: rejected or timed out
drv_mounted  out  NUM_DRIVES  image mounted with non-zero size
drv_protect  out  NUM_DRIVES  image read-only
img_mounted  in  NUM_DRIVES  host mount-change pulse per drive
img_readonly  in  1  read-only flag, sampled with img_mounted
img_size  in  64  image size, sampled with img_mounted
sd_lba  out  NUM_DRIVES*LBA_W  LBA presented to the host per drive
sd_rd  out  NUM_DRIVES  host read request
sd_wr  out  NUM_DRIVES  host write request
sd_ack  in  NUM_DRIVES  host acknowledge (high for the whole transfer)

Behaviour:
- Reset values:
  - sd_rd, sd_wr, drv_busy, drv_done, drv_err = 0; sd_lba = 0.
  - All FSMs IDLE; pending flags 0; timeout counters 0; round-robin pointer 0.
  - drv_mounted and drv_protect are NOT affected by reset. They power up 0, so mount state survives a core reset.
- Mount: img_mounted[i] high → next cycle drv_mounted[i] = (img_size != 0) and drv_protect[i] = img_readonly.
- Request capture, per channel, every cycle:
  - drv_read[i] with drive unmounted → drv_err[i] pulse next cycle; nothing recorded.
  - drv_write[i] with drive unmounted or protected → drv_err[i] pulse next cycle; nothing recorded.
  - Otherwise set rd_pend/wr_pend and latch drv_sector into lba_pend for that type.
  - The capture path is always open, including during REQ/XFER; requests are one-deep per type, and a repeat overwrites the LBA.
- drv_busy[i] = rd_pend | wr_pend | (state != IDLE), registered. It is high the cycle after the request pulse.
- Per-channel FSM:
  - IDLE → REQ when any pend is set and a grant is held (always granted if SERIALIZE=0).
    - Read has priority: if rd_pend, assert sd_rd only, sd_lba = read LBA, clear rd_pend.
    - Else assert sd_wr, sd_lba = write LBA, clear wr_pend.
    - sd_rd and sd_wr are never both high.
  - REQ → XFER on sd_ack rising edge; sd_rd/sd_wr drop in the same transition.
  - REQ → IDLE on timeout: counter reaches TIMEOUT_CYC without ack rise; drop sd_rd/sd_wr, pulse drv_err.
  - XFER → IDLE on sd_ack falling edge; pulse drv_done. A leftover pend starts a new REQ no earlier than the cycle after.
  - sd_lba holds constant from REQ entry until the next REQ entry.
- Stale-ack guard: after reset, or after a timeout abort, a channel does not enter REQ until it has sampled sd_ack[i] = 0 at least once.
- Arbitration (SERIALIZE=1):
  - One grant token; grant is released on return to IDLE.
  - The next grant goes to the lowest index ≥ (last granted + 1) mod NUM_DRIVES with pend set.
  - Simultaneous requests are therefore served in rotating order; no starvation.
- sd_ack edges are detected against a registered copy per channel.
- An ack rise while in IDLE is ignored.
- A write pulse arriving on the same cycle the drive goes protected uses the old protect value.

Decomposition:
- Shared package sd_arb_pkg:
  - state enum {IDLE, REQ, XFER};
  - default TIMEOUT_CYC;
  - the LBA slice helper function.
- Sub-module sd_drive_chan: one per channel via generate. It holds capture, pend/LBA latches, FSM, timeout counter and stale-ack guard, and takes grant_in / returns req_out, idle_out.
- The round-robin arbiter stays in the top.

Test Plan:
- Mount drive 0 (img_size=0x8000, img_readonly=0); drv_read[0] with sector 0x123 → sd_rd[0]=1, sd_lba[0]=0x123, drv_busy=1. Ack pulse 4 cycles → sd_rd drops on ack rise; drv_done pulses on ack fall; busy=0.
- Same cycle drv_read[0] (LBA 5) and drv_write[0] (LBA 9) → read served first (sd_lba=5). After the ack fall, sd_wr=1 with sd_lba=9. sd_rd and sd_wr are never concurrent.
- Write to protected drive 1 (readonly=1) and read to unmounted drive → drv_err pulse each; sd_rd/sd_wr stay 0; busy stays 0.
- TIMEOUT_CYC=16, no ack → sd_rd high 16 cycles then 0, drv_err pulses. With sd_ack held high afterwards, a new request waits until ack=0.
- SERIALIZE=1: drv_read on drives 0 and 1 in the same cycle → drive 0 served, then drive 1. Repeat both → drive 1 first (round-robin).
- Assert reset mid-XFER → all sd_rd/wr/busy = 0 immediately. Mounted/protect are unchanged. The channel idles until ack drops.

Source files
------------

// File: rtl/sd_arb_pkg.sv
// Shared types and helpers for the SD drive arbiter and its per-drive channels.
package sd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } chan_state_t;

  localparam logic [23:0] DEFAULT_TIMEOUT_CYC = 24'd12_000_000;

  // Bit offset of a channel's LBA field inside a packed multi-drive LBA bus.
  function automatic int lba_base(input int chan, input int lba_w);
    return chan * lba_w;
  endfunction

endpackage

// File: rtl/sd_drive_chan.sv
// One drive channel: request capture, pending latches, host handshake FSM,
// REQ timeout and the stale-ack guard that keeps a leftover ack from being
// taken as the answer to a fresh request.
module sd_drive_chan
  import sd_arb_pkg::*;
#(
  parameter int          LBA_W       = 32,
  parameter logic [23:0] TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [LBA_W-1:0] sector,
  input  logic             rd_req,
  input  logic             wr_req,
  input  logic             mnt_pulse,
  input  logic             img_readonly,
  input  logic [63:0]      img_size,
  input  logic             ack,
  input  logic             grant_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             mounted,
  output logic             protect,
  output logic [LBA_W-1:0] lba,
  output logic             rd,
  output logic             wr,
  output logic             req_out,
  output logic             idle_out
);

  chan_state_t      state, state_next;
  logic             rd_pend, wr_pend, rd_pend_next, wr_pend_next;
  logic [LBA_W-1:0] rd_lba_pend, wr_lba_pend;
  logic             serve_is_rd;
  logic             ack_q, ack_clean, ack_rise, ack_fall;
  logic [23:0]      cnt, cnt_inc;
  logic             start_rd, start_wr, timeout_hit, xfer_done;
  logic             rd_accept, wr_accept, reject;

  assign rd_accept = rd_req & mounted;
  assign wr_accept = wr_req & mounted & ~protect;
  assign reject    = (rd_req & ~mounted) | (wr_req & (~mounted | protect));
  assign ack_rise  = ack & ~ack_q;
  assign ack_fall  = ~ack & ack_q;
  assign cnt_inc   = cnt + 24'd1;

  assign rd       = (state == REQ) & serve_is_rd;
  assign wr       = (state == REQ) & ~serve_is_rd;
  assign idle_out = (state == IDLE);
  assign req_out  = (state == IDLE) & ack_clean & (rd_pend | wr_pend);

  // Mount state deliberately has no reset so a core reset keeps the image.
  always_ff @(posedge clk_sys) begin
    if (mnt_pulse) begin
      mounted <= |img_size;
      protect <= img_readonly;
    end
  end

  // Next-state logic: reads win over writes, ack rise beats a timeout.
  always_comb begin
    state_next  = state;
    start_rd    = 1'b0;
    start_wr    = 1'b0;
    timeout_hit = 1'b0;
    xfer_done   = 1'b0;
    case (state)
      IDLE: begin
        if (grant_in && ack_clean) begin
          if (rd_pend) begin
            start_rd   = 1'b1;
            state_next = REQ;
          end else if (wr_pend) begin
            start_wr   = 1'b1;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        if (ack_rise) begin
          state_next = XFER;
        end else if ((TIMEOUT_CYC != 24'd0) && (cnt_inc == TIMEOUT_CYC)) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      XFER: begin
        if (ack_fall) begin
          xfer_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pending flags: a new capture wins over the clear from starting a request.
  always_comb begin
    rd_pend_next = rd_pend;
    wr_pend_next = wr_pend;
    if (start_rd)  rd_pend_next = 1'b0;
    if (start_wr)  wr_pend_next = 1'b0;
    if (rd_accept) rd_pend_next = 1'b1;
    if (wr_accept) wr_pend_next = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Pending latches, presented LBA, timeout counter, ack tracking and pulses.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rd_pend     <= 1'b0;
      wr_pend     <= 1'b0;
      rd_lba_pend <= '0;
      wr_lba_pend <= '0;
      lba         <= '0;
      serve_is_rd <= 1'b0;
      cnt         <= '0;
      ack_q       <= 1'b0;
      ack_clean   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      rd_pend <= rd_pend_next;
      wr_pend <= wr_pend_next;
      if (rd_accept) rd_lba_pend <= sector;
      if (wr_accept) wr_lba_pend <= sector;
      if (start_rd) begin
        lba         <= rd_lba_pend;
        serve_is_rd <= 1'b1;
      end else if (start_wr) begin
        lba         <= wr_lba_pend;
        serve_is_rd <= 1'b0;
      end
      cnt   <= (state == REQ) ? cnt_inc : 24'd0;
      ack_q <= ack;
      if (timeout_hit) ack_clean <= 1'b0;
      else if (!ack)   ack_clean <= 1'b1;
      busy <= rd_pend_next | wr_pend_next | (state_next != IDLE);
      done <= xfer_done;
      err  <= reject | timeout_hit;
    end
  end

endmodule

// File: rtl/sd_drive_arbiter.sv
// Multi-drive front end to the host SD block interface. Each drive gets its
// own channel; when serialised, a round-robin arbiter lets only one channel
// at a time leave IDLE.
module sd_drive_arbiter
  import sd_arb_pkg::*;
#(
  parameter int          NUM_DRIVES  = 2,
  parameter int          LBA_W       = 32,
  parameter logic [23:0] TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  parameter bit          SERIALIZE   = 1'b1
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic [NUM_DRIVES*LBA_W-1:0] drv_sector,
  input  logic [NUM_DRIVES-1:0]       drv_read,
  input  logic [NUM_DRIVES-1:0]       drv_write,
  output logic [NUM_DRIVES-1:0]       drv_busy,
  output logic [NUM_DRIVES-1:0]       drv_done,
  output logic [NUM_DRIVES-1:0]       drv_err,
  output logic [NUM_DRIVES-1:0]       drv_mounted,
  output logic [NUM_DRIVES-1:0]       drv_protect,
  input  logic [NUM_DRIVES-1:0]       img_mounted,
  input  logic                        img_readonly,
  input  logic [63:0]                 img_size,
  output logic [NUM_DRIVES*LBA_W-1:0] sd_lba,
  output logic [NUM_DRIVES-1:0]       sd_rd,
  output logic [NUM_DRIVES-1:0]       sd_wr,
  input  logic [NUM_DRIVES-1:0]       sd_ack
);

  localparam int PTR_W = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1;

  logic [NUM_DRIVES-1:0] req_vec, idle_vec, grant_vec;
  logic [PTR_W-1:0]      rr_ptr, grant_idx, cand_idx;
  logic                  grant_found;

  // Grant the first requester at or after the pointer, only while every
  // channel is idle; the token is implicitly held until the owner idles.
  always_comb begin
    grant_vec   = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    if (!SERIALIZE) begin
      grant_vec = '1;
    end else if (&idle_vec) begin
      for (int k = 0; k < NUM_DRIVES; k++) begin
        cand_idx = PTR_W'((int'(rr_ptr) + k) % NUM_DRIVES);
        if (!grant_found && req_vec[cand_idx]) begin
          grant_found = 1'b1;
          grant_idx   = cand_idx;
        end
      end
      if (grant_found) grant_vec[grant_idx] = 1'b1;
    end
  end

  // Round-robin pointer moves just past the channel that was granted.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_found) begin
      rr_ptr <= (grant_idx == PTR_W'(NUM_DRIVES - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_DRIVES; i++) begin : g_chan
    sd_drive_chan #(
      .LBA_W       (LBA_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_chan (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .sector       (drv_sector[lba_base(i, LBA_W) +: LBA_W]),
      .rd_req       (drv_read[i]),
      .wr_req       (drv_write[i]),
      .mnt_pulse    (img_mounted[i]),
      .img_readonly (img_readonly),
      .img_size     (img_size),
      .ack          (sd_ack[i]),
      .grant_in     (grant_vec[i]),
      .busy         (drv_busy[i]),
      .done         (drv_done[i]),
      .err          (drv_err[i]),
      .mounted      (drv_mounted[i]),
      .protect      (drv_protect[i]),
      .lba          (sd_lba[lba_base(i, LBA_W) +: LBA_W]),
      .rd           (sd_rd[i]),
      .wr           (sd_wr[i]),
      .req_out      (req_vec[i]),
      .idle_out     (idle_vec[i])
    );
  end

endmodule

// File: tb/tb_sd_drive_arbiter.sv
// Bench for sd_drive_arbiter: a host ack model answers requests, and a
// scoreboard of expected (channel, type, LBA) requests is checked in order.
module tb_sd_drive_arbiter;

  localparam int N = 2;
  localparam int W = 32;

  typedef struct packed {
    logic [2:0]  chan;
    logic        is_wr;
    logic [31:0] lba;
  } exp_t;

  logic           clk_sys;
  logic           reset;
  logic [N*W-1:0] drv_sector;
  logic [N-1:0]   drv_read, drv_write;
  logic [N-1:0]   drv_busy, drv_done, drv_err, drv_mounted, drv_protect;
  logic [N-1:0]   img_mounted;
  logic           img_readonly;
  logic [63:0]    img_size;
  logic [N*W-1:0] sd_lba;
  logic [N-1:0]   sd_rd, sd_wr, sd_ack;

  logic [N-1:0] hold_ack = '0;
  logic [N-1:0] auto_ack = '1;
  int           ack_phase [N];
  logic [N-1:0] req_prev = '0;
  logic [N-1:0] ack_prev = '0;
  exp_t         exp_q [$];
  exp_t         mon_e;
  int           n_checks = 0;
  int           n_fail = 0;
  int           overlap_cnt = 0;
  int           hold_viol = 0;
  int           multi_req = 0;
  int           hi_cnt;
  bit           seen;

  sd_drive_arbiter #(
    .NUM_DRIVES  (N),
    .LBA_W       (W),
    .TIMEOUT_CYC (24'd16),
    .SERIALIZE   (1'b1)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .drv_sector   (drv_sector),
    .drv_read     (drv_read),
    .drv_write    (drv_write),
    .drv_busy     (drv_busy),
    .drv_done     (drv_done),
    .drv_err      (drv_err),
    .drv_mounted  (drv_mounted),
    .drv_protect  (drv_protect),
    .img_mounted  (img_mounted),
    .img_readonly (img_readonly),
    .img_size     (img_size),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic expectReq(input int c, input logic is_wr, input logic [31:0] lba);
    exp_t e;
    e.chan  = 3'(c);
    e.is_wr = is_wr;
    e.lba   = lba;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [N-1:0] rd, input logic [N-1:0] wr,
                               input logic [31:0] s0, input logic [31:0] s1);
    @(negedge clk_sys);
    drv_sector = {s1, s0};
    drv_read   = rd;
    drv_write  = wr;
    @(negedge clk_sys);
    drv_read  = '0;
    drv_write = '0;
  endtask

  task automatic mountDrive(input int c, input logic [63:0] size, input logic ro);
    @(negedge clk_sys);
    img_mounted[c] = 1'b1;
    img_size       = size;
    img_readonly   = ro;
    @(negedge clk_sys);
    img_mounted = '0;
  endtask

  task automatic waitDone(input int c, input string tag);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_sys);
      if (drv_done[c]) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput(tag, got, 1);
  endtask

  // Host model: ack a new request one cycle later and hold it four cycles.
  initial begin
    sd_ack = '0;
    for (int c = 0; c < N; c++) ack_phase[c] = 0;
    forever begin
      @(negedge clk_sys);
      #1;
      for (int c = 0; c < N; c++) begin
        if (hold_ack[c]) begin
          sd_ack[c]    = 1'b1;
          ack_phase[c] = 0;
        end else if (ack_phase[c] != 0) begin
          ack_phase[c] = ack_phase[c] - 1;
          sd_ack[c]    = (ack_phase[c] != 0);
        end else begin
          sd_ack[c] = 1'b0;
          if (auto_ack[c] && (sd_rd[c] || sd_wr[c])) ack_phase[c] = 5;
        end
      end
    end
  end

  // Request monitor: pops the scoreboard on each new request, tracks protocol.
  always @(negedge clk_sys) begin
    if ($countones(sd_rd | sd_wr) > 1) multi_req++;
    for (int c = 0; c < N; c++) begin
      if (sd_rd[c] && sd_wr[c]) overlap_cnt++;
      if (ack_prev[c] && sd_ack[c] && (sd_rd[c] || sd_wr[c])) hold_viol++;
      if ((sd_rd[c] || sd_wr[c]) && !req_prev[c]) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_req", 64'(c), 64'hFF);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("req_chan", 64'(c), 64'(mon_e.chan));
          checkOutput("req_is_wr", 64'(sd_wr[c]), 64'(mon_e.is_wr));
          checkOutput("req_lba", 64'(sd_lba[c*W +: W]), 64'(mon_e.lba));
        end
      end
      req_prev[c] = sd_rd[c] || sd_wr[c];
      ack_prev[c] = sd_ack[c];
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    drv_sector   = '0;
    drv_read     = '0;
    drv_write    = '0;
    img_mounted  = '0;
    img_readonly = 1'b0;
    img_size     = '0;
    repeat (3) @(negedge clk_sys);
    checkOutput("rst_sd_rd", sd_rd, 0);
    checkOutput("rst_sd_wr", sd_wr, 0);
    checkOutput("rst_busy", drv_busy, 0);
    checkOutput("rst_done", drv_done, 0);
    checkOutput("rst_err", drv_err, 0);
    checkOutput("rst_lba", sd_lba, 0);
    reset = 1'b0;

    $display("[TB] basic read on drive 0");
    mountDrive(0, 64'h8000, 1'b0);
    checkOutput("mnt0_mounted", drv_mounted[0], 1);
    checkOutput("mnt0_protect", drv_protect[0], 0);
    expectReq(0, 1'b0, 32'h123);
    applyStimulus(2'b01, 2'b00, 32'h123, 32'h0);
    checkOutput("busy_after_pulse", drv_busy[0], 1);
    checkOutput("rd_not_yet", sd_rd[0], 0);
    @(negedge clk_sys);
    checkOutput("rd_asserted", sd_rd[0], 1);
    waitDone(0, "done_basic");
    checkOutput("busy_after_done", drv_busy[0], 0);

    $display("[TB] read priority with captures during a transfer");
    expectReq(0, 1'b0, 32'h40);
    expectReq(0, 1'b0, 32'h5);
    expectReq(0, 1'b1, 32'h9);
    applyStimulus(2'b01, 2'b00, 32'h40, 32'h0);
    applyStimulus(2'b00, 2'b01, 32'h9, 32'h0);
    applyStimulus(2'b01, 2'b00, 32'h5, 32'h0);
    waitDone(0, "done_prio_a");
    checkOutput("busy_with_pend", drv_busy[0], 1);
    waitDone(0, "done_prio_b");
    waitDone(0, "done_prio_c");
    checkOutput("busy_prio_end", drv_busy[0], 0);

    $display("[TB] rejections");
    mountDrive(1, 64'h100, 1'b1);
    checkOutput("mnt1_mounted", drv_mounted[1], 1);
    checkOutput("mnt1_protect", drv_protect[1], 1);
    applyStimulus(2'b00, 2'b10, 32'h0, 32'h10);
    checkOutput("err_wr_protect", drv_err[1], 1);
    checkOutput("busy_wr_protect", drv_busy[1], 0);
    checkOutput("sdwr_wr_protect", sd_wr[1], 0);
    @(negedge clk_sys);
    checkOutput("err_pulse_end", drv_err[1], 0);
    mountDrive(0, 64'h0, 1'b0);
    checkOutput("mnt0_size0", drv_mounted[0], 0);
    applyStimulus(2'b01, 2'b00, 32'h11, 32'h0);
    checkOutput("err_rd_unmounted", drv_err[0], 1);
    checkOutput("busy_rd_unmounted", drv_busy[0], 0);
    mountDrive(0, 64'h8000, 1'b0);

    $display("[TB] write on the cycle protect changes");
    expectReq(0, 1'b1, 32'h77);
    @(negedge clk_sys);
    img_mounted[0]       = 1'b1;
    img_readonly         = 1'b1;
    img_size             = 64'h8000;
    drv_sector[0 +: W]   = 32'h77;
    drv_write[0]         = 1'b1;
    @(negedge clk_sys);
    img_mounted = '0;
    drv_write   = '0;
    checkOutput("protect_now", drv_protect[0], 1);
    checkOutput("err_old_protect", drv_err[0], 0);
    checkOutput("busy_old_protect", drv_busy[0], 1);
    waitDone(0, "done_old_protect");
    applyStimulus(2'b00, 2'b01, 32'h78, 32'h0);
    checkOutput("err_new_protect", drv_err[0], 1);
    mountDrive(0, 64'h8000, 1'b0);

    $display("[TB] timeout and stale ack guard");
    auto_ack[0] = 1'b0;
    expectReq(0, 1'b0, 32'h200);
    applyStimulus(2'b01, 2'b00, 32'h200, 32'h0);
    hi_cnt = 0;
    seen   = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_sys);
      if (sd_rd[0]) begin
        hi_cnt++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
    end
    hold_ack[0] = 1'b1;
    checkOutput("timeout_len", 64'(hi_cnt), 16);
    checkOutput("timeout_err", drv_err[0], 1);
    expectReq(0, 1'b0, 32'h201);
    applyStimulus(2'b01, 2'b00, 32'h201, 32'h0);
    repeat (10) @(negedge clk_sys);
    checkOutput("stale_no_rd", sd_rd[0], 0);
    checkOutput("stale_busy", drv_busy[0], 1);
    auto_ack[0] = 1'b1;
    hold_ack[0] = 1'b0;
    waitDone(0, "done_after_stale");

    $display("[TB] reset during transfer");
    expectReq(0, 1'b0, 32'h2FF);
    applyStimulus(2'b01, 2'b00, 32'h2FF, 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_sys);
      if (sd_ack[0]) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("ack_seen", seen, 1);
    checkOutput("busy_in_xfer", drv_busy[0], 1);
    hold_ack[0] = 1'b1;
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_mid_rd", sd_rd, 0);
    checkOutput("rst_mid_wr", sd_wr, 0);
    checkOutput("rst_mid_busy", drv_busy, 0);
    checkOutput("rst_mid_mounted", drv_mounted, 2'b11);
    checkOutput("rst_mid_protect", drv_protect, 2'b10);
    @(negedge clk_sys);
    reset = 1'b0;
    expectReq(0, 1'b0, 32'h300);
    applyStimulus(2'b01, 2'b00, 32'h300, 32'h0);
    repeat (8) @(negedge clk_sys);
    checkOutput("post_rst_no_rd", sd_rd[0], 0);
    checkOutput("post_rst_busy", drv_busy[0], 1);
    hold_ack[0] = 1'b0;
    waitDone(0, "done_post_rst");

    $display("[TB] round-robin arbitration");
    expectReq(1, 1'b0, 32'hA1);
    expectReq(0, 1'b0, 32'hA0);
    applyStimulus(2'b11, 2'b00, 32'hA0, 32'hA1);
    waitDone(1, "done_rr_a1");
    waitDone(0, "done_rr_a0");
    expectReq(1, 1'b0, 32'hB1);
    applyStimulus(2'b10, 2'b00, 32'h0, 32'hB1);
    waitDone(1, "done_rr_b1");
    expectReq(0, 1'b0, 32'hC0);
    expectReq(1, 1'b0, 32'hC1);
    applyStimulus(2'b11, 2'b00, 32'hC0, 32'hC1);
    waitDone(0, "done_rr_c0");
    waitDone(1, "done_rr_c1");

    repeat (4) @(negedge clk_sys);
    checkOutput("rd_wr_overlap", 64'(overlap_cnt), 0);
    checkOutput("req_held_past_ack", 64'(hold_viol), 0);
    checkOutput("multi_chan_req", 64'(multi_req), 0);
    checkOutput("queue_empty", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
